// File: rtl/burst_ram_responder.sv
// Block-RAM responder for the burst-RAM command interface, mimicking PSRAM burst/calibration timing.
// Optional macro BURST_RAM_RESPONDER_INIT_PATTERN_EN preloads word i with a recognisable pattern.
module burst_ram_responder #(
    parameter int unsigned ADDR_BITWIDTH  = 21,
    parameter int unsigned DEPTH_BITWIDTH = 10,
    parameter int unsigned BURST_LEN      = 4,
    parameter int unsigned READ_LATENCY   = 6,
    parameter int unsigned INIT_CYCLES    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     br_cmd,
    input  logic                     br_cmd_en,
    input  logic [ADDR_BITWIDTH-1:0] br_addr,
    input  logic [63:0]              br_wr_data,
    input  logic [7:0]               br_data_mask,
    output logic [63:0]              br_rd_data,
    output logic                     br_rd_data_valid,
    output logic                     init_calib,
    output logic                     protocol_error
);

    localparam int unsigned NumWords = 1 << DEPTH_BITWIDTH;

    if (BURST_LEN != 4) begin : gen_bad_burst_len
        $error("burst_ram_responder: BURST_LEN must be 4");
    end
    if (DEPTH_BITWIDTH > ADDR_BITWIDTH) begin : gen_bad_depth
        $error("burst_ram_responder: DEPTH_BITWIDTH must be <= ADDR_BITWIDTH");
    end
    if (READ_LATENCY < 2) begin : gen_bad_latency
        $error("burst_ram_responder: READ_LATENCY must be >= 2");
    end
    if (INIT_CYCLES < 1) begin : gen_bad_init
        $error("burst_ram_responder: INIT_CYCLES must be >= 1");
    end

    // Upper address bits are deliberately ignored.
    if (ADDR_BITWIDTH > DEPTH_BITWIDTH) begin : gen_unused_addr
        logic unused_addr_bits;
        assign unused_addr_bits = ^br_addr[ADDR_BITWIDTH-1:DEPTH_BITWIDTH];
    end

    typedef enum logic [2:0] {StInit, StIdle, StWrite, StReadWait, StReadBurst} state_e;
    typedef logic [63:0] mem_t [NumWords];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < int'(NumWords); i++) begin
`ifdef BURST_RAM_RESPONDER_INIT_PATTERN_EN
            m[i] = {32'hA5A5_0000 | {16'h0000, i[15:0]}, i};
`else
            m[i] = 64'h0;
`endif
        end
        return m;
    endfunction

    mem_t mem = mem_init();

    state_e                    state;
    logic [15:0]               cnt;
    logic [1:0]                beat;
    logic [DEPTH_BITWIDTH-1:0] base;

    logic                      cmd_ok;
    logic                      mem_we;
    logic [DEPTH_BITWIDTH-1:0] mem_waddr;
    logic [DEPTH_BITWIDTH-1:0] beat_idx;

    assign cmd_ok   = (state == StIdle) && init_calib;
    assign beat_idx = base + DEPTH_BITWIDTH'(beat);

    // Beat 0 of a write lands in the same cycle the command is accepted.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = beat_idx;
        if (cmd_ok && br_cmd_en && br_cmd) begin
            mem_we    = 1'b1;
            mem_waddr = br_addr[DEPTH_BITWIDTH-1:0];
        end else if (state == StWrite) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (!br_data_mask[b]) begin
                    mem[mem_waddr][8*b +: 8] <= br_wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= StInit;
            cnt              <= '0;
            beat             <= '0;
            base             <= '0;
            br_rd_data       <= '0;
            br_rd_data_valid <= 1'b0;
            init_calib       <= 1'b0;
            protocol_error   <= 1'b0;
        end else begin
            if (br_cmd_en && !cmd_ok) begin
                protocol_error <= 1'b1;
            end
            case (state)
                StInit: begin
                    if (cnt == 16'(INIT_CYCLES - 1)) begin
                        state      <= StIdle;
                        init_calib <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StIdle: begin
                    if (br_cmd_en) begin
                        base <= br_addr[DEPTH_BITWIDTH-1:0];
                        cnt  <= 16'd1;
                        if (br_cmd) begin
                            state <= StWrite;
                            beat  <= 2'd1;
                        end else begin
                            state <= StReadWait;
                            beat  <= 2'd0;
                        end
                    end
                end
                StWrite: begin
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        state <= StIdle;
                    end
                end
                StReadWait: begin
                    // The registered RAM read below supplies the one cycle of BRAM latency.
                    if (cnt == 16'(READ_LATENCY - 1)) begin
                        state            <= StReadBurst;
                        br_rd_data_valid <= 1'b1;
                        br_rd_data       <= mem[beat_idx];
                        beat             <= beat + 2'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StReadBurst: begin
                    if (beat == 2'd0) begin
                        br_rd_data_valid <= 1'b0;
                        state            <= StIdle;
                    end else begin
                        br_rd_data <= mem[beat_idx];
                        beat       <= beat + 2'd1;
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed self-checking bench for burst_ram_responder: calibration, bursts, masks, wrap,
// protocol violations and reset mid-burst.
module tb_burst_ram_responder;

    localparam int unsigned L    = 6;
    localparam int unsigned INIT = 64;

    logic        clk;
    logic        rst_n;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [20:0] br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        init_calib;
    logic        protocol_error;

    int n_cmp = 0;
    int n_bad = 0;

    burst_ram_responder #(
        .ADDR_BITWIDTH (21),
        .DEPTH_BITWIDTH(10),
        .BURST_LEN     (4),
        .READ_LATENCY  (L),
        .INIT_CYCLES   (INIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .init_calib      (init_calib),
        .protocol_error  (protocol_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] init_word(input int i);
`ifdef BURST_RAM_RESPONDER_INIT_PATTERN_EN
        return {32'hA5A5_0000 | {16'h0000, i[15:0]}, i};
`else
        return 64'h0;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", 64'(br_rd_data_valid), 64'd0);
        check_eq("rst_calib", 64'(init_calib), 64'd0);
        check_eq("rst_perr", 64'(protocol_error), 64'd0);
        check_eq("rst_rdata", br_rd_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // inject_k != 0 issues an illegal write command during calibration.
    task automatic calibrate(input int inject_k);
        for (int k = 1; k <= int'(INIT); k++) begin
            @(negedge clk);
            check_eq($sformatf("calib_c%0d", k), 64'(init_calib), 64'(k >= int'(INIT)));
            br_cmd_en = 1'b0;
            if (k == inject_k) begin
                br_cmd_en    = 1'b1;
                br_cmd       = 1'b1;
                br_addr      = 21'h10;
                br_wr_data   = 64'hDEAD_BEEF_DEAD_BEEF;
                br_data_mask = 8'h00;
            end
        end
        br_cmd_en = 1'b0;
    endtask

    task automatic do_write(input logic [20:0] addr,
                            input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3,
                            input logic [7:0] m0, input logic [7:0] m1,
                            input logic [7:0] m2, input logic [7:0] m3);
        logic [63:0] d [4];
        logic [7:0]  m [4];
        d = '{d0, d1, d2, d3};
        m = '{m0, m1, m2, m3};
        @(negedge clk);
        br_cmd_en    = 1'b1;
        br_cmd       = 1'b1;
        br_addr      = addr;
        br_wr_data   = d[0];
        br_data_mask = m[0];
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            br_cmd_en    = 1'b0;
            br_wr_data   = d[k];
            br_data_mask = m[k];
        end
        @(negedge clk);
        br_wr_data   = 64'h0;
        br_data_mask = 8'hFF;
    endtask

    // inject_k: cycle to issue an illegal write; abort_k: cycle to assert reset after checking.
    task automatic do_read(input string tag, input logic [20:0] addr,
                           input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3,
                           input int inject_k, input int abort_k);
        logic [63:0] e [4];
        e = '{e0, e1, e2, e3};
        @(negedge clk);
        br_cmd_en = 1'b1;
        br_cmd    = 1'b0;
        br_addr   = addr;
        for (int k = 1; k <= int'(L) + 4; k++) begin
            @(negedge clk);
            br_cmd_en = 1'b0;
            check_eq($sformatf("%s_v%0d", tag, k), 64'(br_rd_data_valid),
                     64'(k >= int'(L) && k <= int'(L) + 3));
            if (k >= int'(L) && k <= int'(L) + 3) begin
                check_eq($sformatf("%s_d%0d", tag, k - int'(L)), br_rd_data, e[k-int'(L)]);
            end
            if (k == inject_k) begin
                br_cmd_en    = 1'b1;
                br_cmd       = 1'b1;
                br_wr_data   = 64'hDEAD_BEEF_DEAD_BEEF;
                br_data_mask = 8'h00;
            end
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check_eq({tag, "_abort_valid"}, 64'(br_rd_data_valid), 64'd0);
                break;
            end
        end
        br_cmd_en    = 1'b0;
        br_data_mask = 8'hFF;
    endtask

    localparam logic [63:0] Masked = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] Ones   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] Wa     = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] Wb     = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] Wc     = 64'hCCCC_0000_0000_000C;
    localparam logic [63:0] Wd     = 64'hDDDD_0000_0000_000D;

    initial begin
        rst_n        = 1'b1;
        br_cmd       = 1'b0;
        br_cmd_en    = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = 8'hFF;
        #2;
        pulse_reset();
        calibrate(0);
        check_eq("calib_perr", 64'(protocol_error), 64'd0);

        do_write(21'h10, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}},
                 8'h00, 8'h00, 8'h00, 8'h00);
        do_read("wr_rd", 21'h10, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 0, 0);

        do_write(21'h20, Ones, Ones, Ones, Ones, 8'h00, 8'h00, 8'h00, 8'h00);
        do_write(21'h20, 64'h0, 64'h0, 64'h0, 64'h0, 8'hF0, 8'hFF, 8'hFF, 8'hFF);
        do_read("mask", 21'h20, Masked, Ones, Ones, Ones, 0, 0);

        do_write(21'h1003FE, Wa, Wb, Wc, Wd, 8'h00, 8'h00, 8'h00, 8'h00);
        do_read("wrap_hi", 21'h3FE, Wa, Wb, Wc, Wd, 0, 0);
        do_read("wrap_lo", 21'h0, Wc, Wd, init_word(2), init_word(3), 0, 0);
        check_eq("clean_perr", 64'(protocol_error), 64'd0);

        do_read("viol_rw", 21'h10, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 2, 0);
        check_eq("viol_perr", 64'(protocol_error), 64'd1);
        do_read("viol_chk", 21'h10, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 0, 0);
        check_eq("viol_sticky", 64'(protocol_error), 64'd1);

        pulse_reset();
        calibrate(5);
        check_eq("precal_perr", 64'(protocol_error), 64'd1);
        do_read("precal", 21'h10, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 0, 0);

        do_read("abort", 21'h20, Masked, Ones, Ones, Ones, 0, int'(L) + 1);
        @(negedge clk);
        check_eq("abort_perr", 64'(protocol_error), 64'd0);
        rst_n = 1'b1;
        calibrate(0);
        do_read("post_abort", 21'h20, Masked, Ones, Ones, Ones, 0, 0);
        check_eq("final_perr", 64'(protocol_error), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
